pulse_interval_meter: RTL and testbench

Receive-side counterpart to the start/stop pulse generator chain. It measures the interval, in `m_clk` cycles, between a rising edge on `start_pulse` and the next rising edge on `stop_pulse`. It reports each result with a one-cycle valid strobe and keeps running min/max/count statistics. It sits on the board loop-back path, so generated delays can be checked in hardware without a scope.

---
 rtl/pulse_interval_meter_pkg.sv | 7 +
 rtl/pulse_interval_meter_if.sv | 28 ++
 rtl/pulse_interval_meter_edge_sync.sv | 24 ++
 rtl/pulse_interval_meter.sv | 79 +++++++
 tb/tb_pulse_interval_meter.sv | 131 +++++++++++++
 5 files changed

// File: rtl/pulse_interval_meter_pkg.sv
// pulse_interval_meter_pkg: shared state encoding and default parameters.
package pulse_interval_meter_pkg;
  typedef enum logic {IDLE, MEASURE} state_e;
  localparam int CNT_W_DEF = 16;
  localparam int TIMEOUT_DEF = 1000;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/pulse_interval_meter_if.sv
// pulse_interval_meter_if: pulse inputs, clear and result/statistics outputs.
interface pulse_interval_meter_if
  import pulse_interval_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic start_pulse;
  logic stop_pulse;
  logic clear;
  logic [CNT_W-1:0] interval;
  logic interval_valid;
  logic timeout;
  logic stray_stop;
  logic busy;
  logic [CNT_W-1:0] min_interval;
  logic [CNT_W-1:0] max_interval;
  logic [15:0] meas_count;
  modport master (
    output start_pulse, stop_pulse, clear,
    input interval, interval_valid, timeout, stray_stop, busy,
    input min_interval, max_interval, meas_count
  );
  modport slave (
    input start_pulse, stop_pulse, clear,
    output interval, interval_valid, timeout, stray_stop, busy,
    output min_interval, max_interval, meas_count
  );
endinterface

// File: rtl/pulse_interval_meter_edge_sync.sv
// edge_sync: multi-stage synchronizer followed by a registered rising-edge strobe.
module edge_sync
  import pulse_interval_meter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic m_clk,
  input  logic m_rst_n,
  input  logic d,
  output logic rise
);
  // one extra stage holds the previous synchronized value for edge detection
  logic [SYNC_STAGES:0] sync_q;
  logic rise_q;
  always_ff @(posedge m_clk or negedge m_rst_n)
    if (!m_rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-1:0], d};
      rise_q <= sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    end
  assign rise = rise_q;
endmodule

// File: rtl/pulse_interval_meter.sv
// pulse_interval_meter: measures start-to-stop edge separation in m_clk cycles
// and keeps min/max/count statistics of completed measurements.
module pulse_interval_meter
  import pulse_interval_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic m_clk,
  input  logic m_rst_n,
  pulse_interval_meter_if.slave bus
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT);
  state_e state_q;
  logic start_evt, stop_evt;
  logic [CNT_W-1:0] cnt_q, cnt_d, interval_q, min_q, min_d, max_q, max_d;
  logic [15:0] count_q, count_d;
  logic valid_q, timeout_q, stray_q;
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start (
    .m_clk(m_clk), .m_rst_n(m_rst_n), .d(bus.start_pulse), .rise(start_evt)
  );
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop (
    .m_clk(m_clk), .m_rst_n(m_rst_n), .d(bus.stop_pulse), .rise(stop_evt)
  );
  // cnt_d is also the interval reported on a stop in this cycle
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    min_d = cnt_d < min_q ? cnt_d : min_q;
    max_d = cnt_d > max_q ? cnt_d : max_q;
    count_d = &count_q ? count_q : count_q + 16'd1;
  end
  always_ff @(posedge m_clk or negedge m_rst_n)
    if (!m_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      interval_q <= '0;
      valid_q <= 1'b0;
      timeout_q <= 1'b0;
      stray_q <= 1'b0;
      min_q <= '1;
      max_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= 1'b0;
      timeout_q <= 1'b0;
      stray_q <= 1'b0;
      if (bus.clear) begin
        state_q <= IDLE;
        min_q <= '1;
        max_q <= '0;
        count_q <= '0;
      end else if (state_q == IDLE) begin
        if (start_evt) begin
          state_q <= MEASURE;
          cnt_q <= '0;
        end else stray_q <= stop_evt;
      end else if (stop_evt) begin
        state_q <= IDLE;
        interval_q <= cnt_d;
        valid_q <= 1'b1;
        min_q <= min_d;
        max_q <= max_d;
        count_q <= count_d;
      end else if (start_evt) cnt_q <= '0;
      else if (cnt_d == TO_LAST) begin
        state_q <= IDLE;
        timeout_q <= 1'b1;
      end else cnt_q <= cnt_d;
    end
  assign bus.interval = interval_q;
  assign bus.interval_valid = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.stray_stop = stray_q;
  assign bus.busy = state_q == MEASURE;
  assign bus.min_interval = min_q;
  assign bus.max_interval = max_q;
  assign bus.meas_count = count_q;
endmodule

// File: tb/tb_pulse_interval_meter.sv
// tb_pulse_interval_meter: directed edge patterns with hand-computed intervals.
module tb_pulse_interval_meter;
  localparam int TO = 60;
  logic m_clk = 1'b0;
  logic m_rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int vcnt = 0;
  int tcnt = 0;
  int scnt = 0;
  pulse_interval_meter_if #(.CNT_W(16)) bus ();
  pulse_interval_meter #(.CNT_W(16), .TIMEOUT(TO), .SYNC_STAGES(2)) dut (
    .m_clk(m_clk), .m_rst_n(m_rst_n), .bus(bus)
  );
  always #5 m_clk = ~m_clk;
  always @(negedge m_clk) begin
    if (bus.interval_valid) vcnt++;
    if (bus.timeout) tcnt++;
    if (bus.stray_stop) scnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // bit k of sp/pp is the pin level driven at the k-th falling edge
  task automatic drive(input logic [31:0] sp, input logic [31:0] pp);
    for (int k = 0; k < 32; k++) begin
      @(negedge m_clk);
      bus.start_pulse = sp[k];
      bus.stop_pulse = pp[k];
    end
  endtask
  task automatic meas(input int d);
    logic [31:0] s;
    s = 32'd3;
    drive(s, s << d);
  endtask
  task automatic do_clear();
    @(negedge m_clk);
    bus.clear = 1'b1;
    @(negedge m_clk);
    bus.clear = 1'b0;
  endtask
  task automatic chk_stats(input string tag, input int mn, input int mx, input int n);
    chk({tag, "_min"}, 32'(bus.min_interval), 32'(mn));
    chk({tag, "_max"}, 32'(bus.max_interval), 32'(mx));
    chk({tag, "_cnt"}, 32'(bus.meas_count), 32'(n));
  endtask
  initial begin
    bus.start_pulse = 1'b0;
    bus.stop_pulse = 1'b0;
    bus.clear = 1'b0;
    repeat (3) @(negedge m_clk);
    chk("rst_interval", 32'(bus.interval), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.interval_valid), 32'd0);
    chk_stats("rst", 16'hFFFF, 0, 0);
    m_rst_n = 1'b1;
    meas(10);
    chk("basic_interval", 32'(bus.interval), 32'd10);
    chk("basic_strobes", 32'(vcnt), 32'd1);
    chk_stats("basic", 10, 10, 1);
    do_clear();
    meas(5);
    meas(20);
    meas(12);
    chk("seq_interval", 32'(bus.interval), 32'd12);
    chk("seq_strobes", 32'(vcnt), 32'd4);
    chk_stats("seq", 5, 20, 3);
    do_clear();
    chk_stats("clr", 16'hFFFF, 0, 0);
    chk("clr_interval", 32'(bus.interval), 32'd12);
    @(negedge m_clk);
    bus.start_pulse = 1'b1;
    repeat (2) @(negedge m_clk);
    bus.start_pulse = 1'b0;
    repeat (TO + 1) @(negedge m_clk);
    chk("to_busy_before", 32'(bus.busy), 32'd1);
    chk("to_early", 32'(bus.timeout), 32'd0);
    @(negedge m_clk);
    chk("to_strobe", 32'(bus.timeout), 32'd1);
    chk("to_busy_after", 32'(bus.busy), 32'd0);
    @(negedge m_clk);
    chk("to_one_cycle", 32'(bus.timeout), 32'd0);
    chk("to_interval", 32'(bus.interval), 32'd12);
    chk_stats("to", 16'hFFFF, 0, 0);
    drive(32'd0, 32'd3);
    chk("stray", 32'(scnt), 32'd1);
    chk("stray_busy", 32'(bus.busy), 32'd0);
    drive(32'h33, 32'h1800);
    chk("restart_interval", 32'(bus.interval), 32'd7);
    chk_stats("restart", 7, 7, 1);
    chk("restart_strobes", 32'(vcnt), 32'd5);
    drive(32'd3, 32'd3);
    chk("sim_idle_busy", 32'(bus.busy), 32'd1);
    chk("sim_idle_stray", 32'(scnt), 32'd1);
    drive(32'd3, 32'd3);
    chk("sim_meas_busy", 32'(bus.busy), 32'd0);
    chk("sim_meas_interval", 32'(bus.interval), 32'd32);
    chk("sim_meas_strobes", 32'(vcnt), 32'd6);
    chk("sim_meas_stray", 32'(scnt), 32'd1);
    drive(32'd3, 32'd0);
    chk("rstm_busy_pre", 32'(bus.busy), 32'd1);
    m_rst_n = 1'b0;
    #1;
    chk("rstm_busy", 32'(bus.busy), 32'd0);
    chk("rstm_interval", 32'(bus.interval), 32'd0);
    chk_stats("rstm", 16'hFFFF, 0, 0);
    @(negedge m_clk);
    m_rst_n = 1'b1;
    repeat (TO + 10) @(negedge m_clk);
    chk("rstm_no_timeout", 32'(tcnt), 32'd1);
    chk("rstm_no_valid", 32'(vcnt), 32'd6);
    meas(8);
    chk_stats("pre_clr", 8, 8, 1);
    drive(32'd3, 32'd0);
    chk("clrm_busy_pre", 32'(bus.busy), 32'd1);
    do_clear();
    chk("clrm_busy", 32'(bus.busy), 32'd0);
    chk("clrm_interval", 32'(bus.interval), 32'd8);
    chk_stats("clrm", 16'hFFFF, 0, 0);
    repeat (TO + 10) @(negedge m_clk);
    chk("clrm_no_timeout", 32'(tcnt), 32'd1);
    chk("clrm_no_valid", 32'(vcnt), 32'd7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
